// File: rtl/sample_mem_responder_if.sv
// Bus bundle for sample_mem_responder: a valid-only write port, a read request
// channel, a read response channel and status outputs.
//
// Handshake rule for rd_req and rd_rsp: a beat transfers on a rising clk edge
// where valid and ready are both high. Once valid is raised, the producer keeps
// valid and its payload unchanged until that transfer happens. wr_valid has no
// ready: the write happens on the edge where it is high, or it is dropped.
interface sample_mem_responder_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;

  logic          rd_rsp_valid;
  logic          rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;

  logic          init_busy;
  logic [15:0]   rd_count;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req_valid, rd_req_addr,
    output rd_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  init_busy, rd_count
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req_valid, rd_req_addr,
    input  rd_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output init_busy, rd_count
  );
endinterface

// File: rtl/sample_mem_responder.sv
// Memory responder: clears its RAM after reset, then serves writes and
// in-order reads through a 2-entry response FIFO.
module sample_mem_responder #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  sample_mem_responder_if.slave  bus,
  output logic                   state_o
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEPTH = 2 ** AW;

  // ---------------------------------------------------------------------------
  // Clear/run FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [AW-1:0] iter_q, iter_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          init_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    init_busy = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    case (state_q)
      ST_INIT: begin
        // One entry cleared per cycle; user writes are dropped, not queued.
        init_busy = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = iter_q;
        mem_wdata = '0;
        iter_d    = iter_q + 1'b1;
        if (iter_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = bus.wr_valid;
      end
      default: begin
        state_d = ST_INIT;
        iter_d  = '0;
      end
    endcase
    // The reset edge must not disturb memory contents.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  assign state_o = state_q;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read request path
  // ---------------------------------------------------------------------------
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic          rd_req_ready;
  logic          rd_fire;
  logic          rsp_fire;
  logic          wr_hit;
  logic [DW-1:0] rd_data;

  // The array is read in the accepting cycle and the word goes straight into
  // the FIFO, so nothing is ever in flight outside the FIFO. Ready therefore
  // depends only on registered occupancy, never on rd_rsp_ready.
  assign rd_req_ready = (state_q == ST_RUN) && (fifo_cnt_q < 2'd2);
  assign rd_fire      = bus.rd_req_valid && rd_req_ready;

  // Write-first: a same-cycle write to the read address wins over the array.
  assign wr_hit  = bus.wr_valid && (bus.wr_addr == bus.rd_req_addr);
  assign rd_data = wr_hit ? bus.wr_data : mem_q[bus.rd_req_addr];

  // ---------------------------------------------------------------------------
  // 2-entry response FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] fifo_q [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic          rsp_valid;

  assign rsp_valid = (fifo_cnt_q != 2'd0);
  assign rsp_fire  = rsp_valid && bus.rd_rsp_ready;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (rd_fire) begin
      wptr_d = ~wptr_q;
    end
    if (rsp_fire) begin
      rptr_d = ~rptr_q;
    end
    case ({rd_fire, rsp_fire})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // A push never lands on the head slot while it is occupied, so the head
  // word stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      fifo_q[wptr_q] <= rd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted-read counter
  // ---------------------------------------------------------------------------
  logic [15:0] rd_count_q, rd_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    if (rd_fire) begin
      rd_count_d = rd_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= 16'd0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rd_req_ready = rd_req_ready;
  assign bus.rd_rsp_valid = rsp_valid;
  assign bus.rd_rsp_data  = fifo_q[rptr_q];
  assign bus.init_busy    = init_busy;
  assign bus.rd_count     = rd_count_q;

endmodule

// File: tb/tb_sample_mem_responder.sv
// Directed and randomized checks of sample_mem_responder against a queue-based
// model of the memory, the response stream and the clear period.
module tb_sample_mem_responder;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sample_mem_responder_if #(.AW(AW), .DW(DW)) bus_if ();
  logic state_dbg;

  sample_mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .state_o (state_dbg)
  );

  // Reference model
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            init_left;
  logic [15:0]   model_count;
  int            reads_since_reset;
  bit            last_accept;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("init_busy",    DW'(bus_if.init_busy),    DW'(init_left > 0));
    chk("rd_req_ready", DW'(bus_if.rd_req_ready), DW'(init_left == 0 && exp_q.size() < 2));
    chk("rd_rsp_valid", DW'(bus_if.rd_rsp_valid), DW'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("rd_rsp_data", bus_if.rd_rsp_data, exp_q[0]);
    chk("rd_count",     DW'(bus_if.rd_count),     DW'(model_count));
  endtask

  // Check outputs, advance the model by one edge using the current inputs,
  // then step the DUT across the same edge.
  task automatic cycle();
    logic [DW-1:0] rd_val;
    bit acc;
    check_outputs();
    acc = 1'b0;
    if (reset) begin
      init_left = DEPTH;
      exp_q.delete();
      model_count = '0;
      reads_since_reset = 0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) begin
        foreach (model_mem[i]) model_mem[i] = '0;
      end
    end else begin
      acc = bus_if.rd_req_valid && (exp_q.size() < 2);
      rd_val = (bus_if.wr_valid && bus_if.wr_addr == bus_if.rd_req_addr)
               ? bus_if.wr_data : model_mem[bus_if.rd_req_addr];
      if (exp_q.size() > 0 && bus_if.rd_rsp_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(rd_val);
        model_count++;
        reads_since_reset++;
      end
      if (bus_if.wr_valid) model_mem[bus_if.wr_addr] = bus_if.wr_data;
    end
    last_accept = acc;
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic issue_read(input logic [AW-1:0] addr);
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_req_addr  = addr;
    last_accept = 1'b0;
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (last_accept) break;
    end
    if (!last_accept) begin
      checks++;
      errors++;
      $error("FAIL read_accept_timeout addr=%0d observed=no_accept expected=accept", addr);
    end
    bus_if.rd_req_valid = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = addr;
    bus_if.wr_data  = data;
    cycle();
    bus_if.wr_valid = 1'b0;
  endtask

  task automatic drain();
    bus_if.rd_rsp_ready = 1'b1;
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) cycle();
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    bus_if.wr_valid     = 1'b0;
    bus_if.wr_addr      = '0;
    bus_if.wr_data      = '0;
    bus_if.rd_req_valid = 1'b0;
    bus_if.rd_req_addr  = '0;
    bus_if.rd_rsp_ready = 1'b0;
    foreach (model_mem[i]) model_mem[i] = '0;
    @(posedge clk);
    #1;
    init_left = DEPTH;
    model_count = '0;
    reads_since_reset = 0;
    repeat (3) cycle();
    reset = 1'b0;

    // Clear period, with writes to an already-cleared address that must drop
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= 20) begin
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 8'd9;
        bus_if.wr_data  = 32'h1234_5678;
      end
      cycle();
    end
    bus_if.wr_valid = 1'b0;
    chk("init_done", DW'(bus_if.init_busy), '0);

    // Every address reads back zero
    bus_if.rd_rsp_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) issue_read(AW'(a));
    drain();

    // Basic write then read
    write_word(8'd127, 32'd2301383);
    issue_read(8'd127);
    chk("basic_valid", DW'(bus_if.rd_rsp_valid), DW'(1));
    chk("basic_data", bus_if.rd_rsp_data, 32'd2301383);
    drain();

    // Same-cycle write and read to one address
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = 8'd5;
    bus_if.wr_data  = 32'hDEAD_BEEF;
    issue_read(8'd5);
    bus_if.wr_valid = 1'b0;
    chk("bypass_data", bus_if.rd_rsp_data, 32'hDEAD_BEEF);
    drain();

    // Backpressure: third read waits until the FIFO frees a slot
    write_word(8'd1, 32'h0000_0111);
    write_word(8'd2, 32'h0000_0222);
    write_word(8'd3, 32'h0000_0333);
    bus_if.rd_rsp_ready = 1'b0;
    issue_read(8'd1);
    issue_read(8'd2);
    chk("bp_ready_low", DW'(bus_if.rd_req_ready), '0);
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_req_addr  = 8'd3;
    repeat (3) cycle();
    chk("bp_head_stable", bus_if.rd_rsp_data, 32'h0000_0111);
    bus_if.rd_rsp_ready = 1'b1;
    issue_read(8'd3);
    drain();

    // Randomized traffic over a small address window to force collisions
    for (int i = 0; i < 500; i++) begin
      bus_if.wr_valid     = 1'($urandom_range(0, 1));
      bus_if.wr_addr      = AW'($urandom_range(0, 15));
      bus_if.wr_data      = $urandom;
      bus_if.rd_req_valid = 1'($urandom_range(0, 1));
      bus_if.rd_req_addr  = AW'($urandom_range(0, 15));
      bus_if.rd_rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus_if.wr_valid     = 1'b0;
    bus_if.rd_req_valid = 1'b0;
    drain();

    // Reset with two responses pending
    bus_if.rd_rsp_ready = 1'b0;
    issue_read(8'd1);
    issue_read(8'd2);
    chk("pending_valid", DW'(bus_if.rd_rsp_valid), DW'(1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_rsp_valid", DW'(bus_if.rd_rsp_valid), '0);
    chk("rst_rd_count", DW'(bus_if.rd_count), '0);
    chk("rst_init_busy", DW'(bus_if.init_busy), DW'(1));
    for (int i = 0; i < DEPTH; i++) cycle();
    chk("reinit_done", DW'(bus_if.init_busy), '0);
    bus_if.rd_rsp_ready = 1'b1;
    issue_read(8'd127);
    chk("reinit_cleared", bus_if.rd_rsp_data, '0);

    // Counter wrap: 65537 accepted reads since the reset
    bus_if.rd_req_valid = 1'b1;
    for (int n = 0; n < 70000 && reads_since_reset < 65537; n++) begin
      bus_if.rd_req_addr = AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    bus_if.rd_req_valid = 1'b0;
    chk("count_wrap", DW'(bus_if.rd_count), DW'(1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
